// File: rtl/lamp_seq_pkg.sv
// Shared types and helpers for the turn lamp sequencer.
//   state_t : sequencer FSM states
//   therm() : thermometer code with the lowest `step` bits set, limited to `lamps`
package lamp_seq_pkg;

  // Widest lamp bank therm() can describe; callers cast the result down to LAMPS.
  localparam int MAX_LAMPS = 32;

  typedef enum logic [2:0] {
    IDLE,
    LEFT,
    RIGHT,
    HAZ_ON,
    HAZ_OFF
  } state_t;

  function automatic logic [MAX_LAMPS-1:0] therm(input int step, input int lamps);
    logic [MAX_LAMPS-1:0] t;
    t = '0;
    for (int i = 0; i < MAX_LAMPS; i++)
      t[i] = (i < lamps) && (i < step);
    return t;
  endfunction

endpackage

// File: rtl/turn_lamp_sequencer_tick_prescaler.sv
// Animation-rate prescaler.
//   clk  : clock
//   rst  : synchronous active-high reset
//   clr  : restart the count (state change in the parent)
//   en   : count enable; count is held at 0 while low
//   tick : one-cycle pulse every TICK_DIV enabled clocks
module tick_prescaler #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // Combinational off the registered count; with TICK_DIV=1 this is just en.
  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr || !en || tick) cnt <= '0;
    else                           cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/turn_lamp_sequencer.sv
// Turn / hazard / brake lamp sequencer with LAMPS lamps per side.
//   clk, rst          : clock, synchronous active-high reset
//   lt, rt, haz, brk  : level requests (lt&&rt counts as hazard)
//   li, ri            : left / right lamps, bit 0 innermost, registered
//   active            : registered, high whenever the FSM is not IDLE
module turn_lamp_sequencer
  import lamp_seq_pkg::*;
#(
  parameter int LAMPS    = 3,
  parameter int TICK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lt,
  input  logic             rt,
  input  logic             haz,
  input  logic             brk,
  output logic [LAMPS-1:0] li,
  output logic [LAMPS-1:0] ri,
  output logic             active
);

  localparam int SW = $clog2(LAMPS + 1);
  localparam logic [SW-1:0] LAST = SW'(LAMPS);
  localparam logic [LAMPS-1:0] ALL = '1;

  state_t           state, state_nxt;
  logic [SW-1:0]    step, step_nxt;
  logic             tick, hz, own, pre_clr;
  logic [LAMPS-1:0] th, li_nxt, ri_nxt;

  assign hz      = haz | (lt & rt);
  assign own     = (state == LEFT) ? lt : rt;
  assign pre_clr = (state_nxt != state);

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_pre (
    .clk  (clk),
    .rst  (rst),
    .clr  (pre_clr),
    .en   (state != IDLE),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      step  <= '0;
    end else begin
      state <= state_nxt;
      step  <= step_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    case (state)
      IDLE: begin
        if (hz) begin
          state_nxt = HAZ_ON;
        end else if (lt) begin
          state_nxt = LEFT;
          step_nxt  = SW'(1);
        end else if (rt) begin
          state_nxt = RIGHT;
          step_nxt  = SW'(1);
        end
      end
      LEFT, RIGHT: begin
        // Hazard preempts immediately, even mid-step.
        if (hz) begin
          state_nxt = HAZ_ON;
          step_nxt  = '0;
        end else if (tick) begin
          if (step == '0) begin
            if (own) step_nxt  = SW'(1);
            else     state_nxt = IDLE;
          end else if (step == LAST) begin
            step_nxt = '0;
          end else begin
            step_nxt = step + SW'(1);
          end
        end
      end
      HAZ_ON: begin
        if (tick) state_nxt = HAZ_OFF;
      end
      HAZ_OFF: begin
        // Only the dark phase may exit, so it always completes.
        if (tick) state_nxt = hz ? HAZ_ON : IDLE;
      end
      default: begin
        state_nxt = IDLE;
        step_nxt  = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so every input
  // sampled on an edge shows up on the lamps right after that edge.
  always_comb begin
    th     = LAMPS'(therm(int'(step_nxt), LAMPS));
    li_nxt = '0;
    ri_nxt = '0;
    case (state_nxt)
      IDLE: begin
        if (brk) begin
          li_nxt = ALL;
          ri_nxt = ALL;
        end
      end
      LEFT: begin
        li_nxt = th;
        ri_nxt = brk ? ALL : '0;
      end
      RIGHT: begin
        ri_nxt = th;
        li_nxt = brk ? ALL : '0;
      end
      HAZ_ON: begin
        li_nxt = ALL;
        ri_nxt = ALL;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      li     <= '0;
      ri     <= '0;
      active <= 1'b0;
    end else begin
      li     <= li_nxt;
      ri     <= ri_nxt;
      active <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_turn_lamp_sequencer.sv
// Scoreboard bench: three sequencer configurations share one stimulus stream.
// Each driven cycle pushes the expected post-edge outputs of all three into a
// queue; an independent monitor pops and compares after every rising edge.
module tb_turn_lamp_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1, lt = 1'b0, rt = 1'b0, haz = 1'b0, brk = 1'b0;

  logic [2:0] li0, ri0;
  logic [5:0] li1, ri1;
  logic [0:0] li2, ri2;
  logic       act0, act1, act2;

  always #5 clk = ~clk;

  turn_lamp_sequencer #(.LAMPS(3), .TICK_DIV(4)) u0 (
    .clk(clk), .rst(rst), .lt(lt), .rt(rt), .haz(haz), .brk(brk),
    .li(li0), .ri(ri0), .active(act0));
  turn_lamp_sequencer #(.LAMPS(6), .TICK_DIV(4)) u1 (
    .clk(clk), .rst(rst), .lt(lt), .rt(rt), .haz(haz), .brk(brk),
    .li(li1), .ri(ri1), .active(act1));
  turn_lamp_sequencer #(.LAMPS(1), .TICK_DIV(1)) u2 (
    .clk(clk), .rst(rst), .lt(lt), .rt(rt), .haz(haz), .brk(brk),
    .li(li2), .ri(ri2), .active(act2));

  typedef struct packed {
    logic [2:0][7:0] li;
    logic [2:0][7:0] ri;
    logic [2:0]      act;
  } exp_t;

  exp_t sb[$];
  int   nchk = 0;
  int   nerr = 0;

  // Reference model: mode, number of lit lamps, cycles left in current phase.
  localparam int M_IDLE = 0, M_LEFT = 1, M_RIGHT = 2, M_HON = 3, M_HOFF = 4;
  int lmp[3] = '{3, 6, 1};
  int dv[3]  = '{4, 4, 1};
  int md[3]  = '{0, 0, 0};
  int lit[3] = '{0, 0, 0};
  int tm[3]  = '{0, 0, 0};

  task automatic drive(input bit r, input bit l, input bit rr, input bit h,
                       input bit b, input int n);
    exp_t e;
    bit   hz, own;
    int   full, thv;
    repeat (n) begin
      @(negedge clk);
      rst = r; lt = l; rt = rr; haz = h; brk = b;
      e  = '0;
      hz = h || (l && rr);
      for (int k = 0; k < 3; k++) begin
        if (r) begin
          md[k] = M_IDLE; lit[k] = 0; tm[k] = 0;
        end else begin
          case (md[k])
            M_IDLE: begin
              if (hz)      begin md[k] = M_HON;   tm[k] = dv[k]; end
              else if (l)  begin md[k] = M_LEFT;  lit[k] = 1; tm[k] = dv[k]; end
              else if (rr) begin md[k] = M_RIGHT; lit[k] = 1; tm[k] = dv[k]; end
            end
            M_LEFT, M_RIGHT: begin
              own = (md[k] == M_LEFT) ? l : rr;
              if (hz) begin
                md[k] = M_HON; lit[k] = 0; tm[k] = dv[k];
              end else begin
                tm[k]--;
                if (tm[k] == 0) begin
                  tm[k] = dv[k];
                  if (lit[k] == 0) begin
                    if (own) lit[k] = 1;
                    else     md[k] = M_IDLE;
                  end else if (lit[k] == lmp[k]) lit[k] = 0;
                  else lit[k]++;
                end
              end
            end
            M_HON: begin
              tm[k]--;
              if (tm[k] == 0) begin md[k] = M_HOFF; tm[k] = dv[k]; end
            end
            default: begin
              tm[k]--;
              if (tm[k] == 0) begin
                tm[k] = dv[k];
                md[k] = hz ? M_HON : M_IDLE;
              end
            end
          endcase
          full = (1 << lmp[k]) - 1;
          thv  = (1 << lit[k]) - 1;
          case (md[k])
            M_IDLE:  begin e.li[k] = b ? 8'(full) : 8'd0; e.ri[k] = e.li[k]; end
            M_LEFT:  begin e.li[k] = 8'(thv); e.ri[k] = b ? 8'(full) : 8'd0; end
            M_RIGHT: begin e.ri[k] = 8'(thv); e.li[k] = b ? 8'(full) : 8'd0; end
            M_HON:   begin e.li[k] = 8'(full); e.ri[k] = 8'(full); end
            default: ;
          endcase
          e.act[k] = (md[k] != M_IDLE);
        end
      end
      sb.push_back(e);
    end
  endtask

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] want);
    nchk++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s at %0t: got=%b want=%b", nm, $time, got, want);
    end
  endtask

  // Monitor: outputs are stable 1 time unit after each rising edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        chk("li0",  {5'b0, li0},  x.li[0]);
        chk("ri0",  {5'b0, ri0},  x.ri[0]);
        chk("act0", {7'b0, act0}, {7'b0, x.act[0]});
        chk("li1",  {2'b0, li1},  x.li[1]);
        chk("ri1",  {2'b0, ri1},  x.ri[1]);
        chk("act1", {7'b0, act1}, {7'b0, x.act[1]});
        chk("li2",  {7'b0, li2},  x.li[2]);
        chk("ri2",  {7'b0, ri2},  x.ri[2]);
        chk("act2", {7'b0, act2}, {7'b0, x.act[2]});
      end
    end
  end

  initial begin
    bit r, l, rr, h, b;
    // reset with lt held, then first lamp right after release
    drive(1, 1, 0, 0, 1, 2);
    drive(0, 1, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 30);
    // single left pulse
    drive(0, 1, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 30);
    // held right, then drop mid-sequence
    drive(0, 0, 1, 0, 0, 38);
    drive(0, 0, 0, 0, 0, 30);
    // hazard held, dropped during an ON phase
    drive(0, 0, 0, 1, 0, 10);
    drive(0, 0, 0, 0, 0, 12);
    // hazard preempts left while 011 is shown
    drive(0, 1, 0, 0, 0, 6);
    drive(0, 1, 0, 1, 0, 3);
    drive(0, 0, 0, 0, 0, 12);
    // brake during right turn, then in idle
    drive(0, 0, 1, 0, 1, 20);
    drive(0, 0, 0, 0, 0, 30);
    drive(0, 0, 0, 0, 1, 3);
    // lt and rt together
    drive(0, 1, 1, 0, 0, 10);
    drive(0, 0, 0, 0, 0, 12);
    // randomized stretch with occasional resets
    repeat (300) begin
      r  = ($urandom_range(0, 99) < 2);
      l  = ($urandom_range(0, 99) < 40);
      rr = ($urandom_range(0, 99) < 40);
      h  = ($urandom_range(0, 99) < 10);
      b  = ($urandom_range(0, 99) < 30);
      drive(r, l, rr, h, b, int'($urandom_range(1, 12)));
    end
    drive(0, 0, 0, 0, 0, 40);
    @(posedge clk);
    #3;
    nchk++;
    if (sb.size() != 0) begin
      nerr++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
